// File: rtl/and_arb_pkg.sv
// Shared defaults and helpers for the arbitrated two-stage AND pipeline.
package and_arb_pkg;
  localparam int N_REQ_DEF = 4;
  localparam int W_DEF     = 8;
  localparam int ID_W_MAX  = 4;

  // An index width of at least one bit keeps ports legal for tiny N.
  function automatic int id_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  typedef struct packed {
    logic                vld;
    logic [W_DEF-1:0]    data;
    logic [ID_W_MAX-1:0] id;
  } stage_t;
endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester at or after ptr wins.
module rr_arbiter
  import and_arb_pkg::*;
#(
  parameter int N   = N_REQ_DEF,
  parameter int IDW = id_w(N)
)(
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] ptr,
  input  logic           en,
  output logic [N-1:0]   gnt,
  output logic [IDW-1:0] gnt_id,
  output logic           any
);
  logic [IDW:0]   sum;
  logic [IDW-1:0] idx;

  always_comb begin
    gnt    = '0;
    gnt_id = '0;
    any    = 1'b0;
    sum    = '0;
    idx    = '0;
    for (int k = 0; k < N; k++) begin
      sum = {1'b0, ptr} + (IDW+1)'(k);
      if (sum >= (IDW+1)'(N)) sum = sum - (IDW+1)'(N);
      idx = sum[IDW-1:0];
      if (!any && req[idx]) begin
        any    = 1'b1;
        gnt_id = idx;
      end
    end
    if (any && en) gnt[gnt_id] = 1'b1;
  end
endmodule

// File: rtl/and_pipe_arbiter.sv
// N_REQ requesters share one registered a&b pipe (ab stage, q stage), in order.
// Define AND_ARB_STATS_EN to add per-requester saturating grant counters.
module and_pipe_arbiter
  import and_arb_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF,
  parameter int W     = W_DEF
`ifdef AND_ARB_STATS_EN
  , parameter int CNT_W = 16
`endif
)(
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [N_REQ-1:0]           req_valid,
  input  logic [N_REQ-1:0][W-1:0]    req_a,
  input  logic [N_REQ-1:0][W-1:0]    req_b,
  output logic [N_REQ-1:0]           req_ready,
  output logic                       out_valid,
  output logic [W-1:0]               out_data,
  output logic [id_w(N_REQ)-1:0]     out_id,
  input  logic                       out_ready,
  output logic                       busy
`ifdef AND_ARB_STATS_EN
  ,
  input  logic                       stats_clr,
  output logic [N_REQ-1:0][CNT_W-1:0] grant_cnt
`endif
);
  localparam int ID_W = id_w(N_REQ);

  typedef struct packed {
    logic            vld;
    logic [W-1:0]    data;
    logic [ID_W-1:0] id;
  } stg_t;

  stg_t            ab_q, ab_d, q_q, q_d;
  logic [ID_W-1:0] ptr_q, ptr_d, gnt_id;
  logic [N_REQ-1:0] gnt;
  logic            any, s1_en, s2_en, accept;

  assign s2_en = !q_q.vld || out_ready;
  assign s1_en = !ab_q.vld || s2_en;

  // Gating with reset_n keeps req_ready low while the block is held in reset.
  rr_arbiter #(.N(N_REQ), .IDW(ID_W)) u_arb (
    .req    (req_valid),
    .ptr    (ptr_q),
    .en     (s1_en & reset_n),
    .gnt    (gnt),
    .gnt_id (gnt_id),
    .any    (any)
  );

  assign req_ready = gnt;
  assign accept    = |(req_valid & gnt);

  always_comb begin
    ab_d  = ab_q;
    q_d   = q_q;
    ptr_d = ptr_q;
    if (s2_en) q_d = ab_q;
    if (s1_en) begin
      ab_d.vld = accept;
      if (accept) begin
        ab_d.data = req_a[gnt_id] & req_b[gnt_id];
        ab_d.id   = gnt_id;
      end
    end
    if (accept) ptr_d = (gnt_id == ID_W'(N_REQ-1)) ? '0 : gnt_id + ID_W'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ab_q  <= '0;
      q_q   <= '0;
      ptr_q <= '0;
    end else begin
      ab_q  <= ab_d;
      q_q   <= q_d;
      ptr_q <= ptr_d;
    end
  end

  assign out_valid = q_q.vld;
  assign out_data  = q_q.data;
  assign out_id    = q_q.id;
  assign busy      = ab_q.vld | q_q.vld;

`ifdef AND_ARB_STATS_EN
  logic [N_REQ-1:0][CNT_W-1:0] cnt_q, cnt_d;

  // Clear beats a coincident accept; counters stick at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    for (int i = 0; i < N_REQ; i++) begin
      if (stats_clr) cnt_d[i] = '0;
      else if (req_valid[i] && gnt[i] && !(&cnt_q[i])) cnt_d[i] = cnt_q[i] + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  assign grant_cnt = cnt_q;
`endif
endmodule

// File: tb/tb_and_pipe_arbiter.sv
// Scoreboard bench for and_pipe_arbiter (N_REQ=4 main instance, N_REQ=2 wrap instance).
module tb_and_pipe_arbiter;
  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic [3:0]      req_valid = '0;
  logic [3:0][7:0] req_a = '0, req_b = '0;
  logic [3:0]      req_ready;
  logic            out_valid, out_ready = 1'b0, busy;
  logic [7:0]      out_data;
  logic [1:0]      out_id;

  logic [1:0]      v2 = '0, rdy2;
  logic [1:0][7:0] a2 = '0, b2 = '0;
  logic            ov2, busy2, oid2;
  logic [7:0]      od2;

  int checks = 0;
  int errors = 0;

  typedef struct { logic [1:0] id; logic [7:0] data; } exp_t;
  exp_t sb[$];

`ifdef AND_ARB_STATS_EN
  logic            stats_clr = 1'b0;
  logic [3:0][2:0] grant_cnt;
  logic [1:0][15:0] grant_cnt2;
`endif

  always #5 clk = ~clk;

  and_pipe_arbiter #(
    .N_REQ(4), .W(8)
`ifdef AND_ARB_STATS_EN
    , .CNT_W(3)
`endif
  ) dut (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready), .out_valid(out_valid), .out_data(out_data), .out_id(out_id),
    .out_ready(out_ready), .busy(busy)
`ifdef AND_ARB_STATS_EN
    , .stats_clr(stats_clr), .grant_cnt(grant_cnt)
`endif
  );

  and_pipe_arbiter #(.N_REQ(2), .W(8)) dut2 (
    .clk(clk), .reset_n(reset_n), .req_valid(v2), .req_a(a2), .req_b(b2),
    .req_ready(rdy2), .out_valid(ov2), .out_data(od2), .out_id(oid2),
    .out_ready(1'b1), .busy(busy2)
`ifdef AND_ARB_STATS_EN
    , .stats_clr(1'b0), .grant_cnt(grant_cnt2)
`endif
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic push(input logic [1:0] id, input logic [7:0] d);
    exp_t e;
    e.id = id; e.data = d;
    sb.push_back(e);
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    req_valid = '0; v2 = '0;
`ifdef AND_ARB_STATS_EN
    stats_clr = 1'b0;
`endif
    reset_n = 1'b0;
    step(); step();
    reset_n = 1'b1;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 20) begin
      @(negedge clk); n++;
    end
    chk("drain_empty", sb.size(), 0);
    step();
  endtask

  // Monitor: every transfer (out_valid && out_ready) must match the next expected entry.
  always @(negedge clk) begin
    if (reset_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL sb_unexpected: got id %0d data %0h expected nothing", out_id, out_data);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("sb_id", out_id, e.id);
        chk("sb_data", out_data, e.data);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  logic [3:0] g_all [6] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
  logic [3:0] g_bp  [5] = '{4'b0001, 4'b0010, 4'b0000, 4'b0000, 4'b0000};

  initial begin
    // Reset state, with requests pending
    req_valid = 4'hF;
    repeat (2) @(negedge clk);
    chk("rst_ready", req_ready, 4'b0000);
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_data", out_data, 8'h00);
    chk("rst_id", out_id, 2'd0);
    req_valid = '0;
    step();
    reset_n = 1'b1;

    // Single requester 2, latency of two edges
    req_a[2] = 8'hF0; req_b[2] = 8'h3C; out_ready = 1'b1;
    req_valid = 4'b0100; push(2'd2, 8'h30);
    @(negedge clk); chk("t1_ready", req_ready, 4'b0100);
    step(); req_valid = '0;
    @(negedge clk); chk("t1_lat_v0", out_valid, 1'b0); chk("t1_lat_busy", busy, 1'b1);
    @(negedge clk); chk("t1_lat_v1", out_valid, 1'b1);
    drain();

    // All requesting, full throughput
    do_reset();
    for (int i = 0; i < 4; i++) req_a[i] = 8'hFF;
    req_b[0] = 8'h11; req_b[1] = 8'h22; req_b[2] = 8'h33; req_b[3] = 8'h44;
    push(0, 8'h11); push(1, 8'h22); push(2, 8'h33); push(3, 8'h44); push(0, 8'h11); push(1, 8'h22);
    req_valid = 4'hF;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("t2_grant", req_ready, g_all[i]);
      if (i >= 2) chk("t2_tput", out_valid, 1'b1);
      step();
    end
    req_valid = '0;
    drain();

    // Backpressure: two accepts then stall, q stable
    do_reset();
    out_ready = 1'b0; req_valid = 4'hF;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t3_grant", req_ready, g_bp[i]);
      if (i >= 2) begin
        chk("t3_q_data", out_data, 8'h11);
        chk("t3_q_id", out_id, 2'd0);
      end
      step();
    end
    push(0, 8'h11); push(1, 8'h22); push(2, 8'h33);
    out_ready = 1'b1;
    @(negedge clk); chk("t3_release", req_ready, 4'b0100);
    step(); req_valid = '0;
    drain();

    // Reset with both stages full
    do_reset();
    out_ready = 1'b0; req_valid = 4'hF;
    step(); step();
    @(negedge clk); chk("t4_full_busy", busy, 1'b1); chk("t4_full_v", out_valid, 1'b1);
    reset_n = 1'b0;
    #1;
    chk("t4_rst_v", out_valid, 1'b0);
    chk("t4_rst_busy", busy, 1'b0);
    chk("t4_rst_ready", req_ready, 4'b0000);
    step();
    reset_n = 1'b1; out_ready = 1'b1; push(0, 8'h11);
    @(negedge clk); chk("t4_first", req_ready, 4'b0001);
    step(); req_valid = '0;
    drain();

    // Data extremes and a lone requester held (ptr is 1 here)
    req_a[0] = 8'hFF; req_b[0] = 8'hFF; req_a[3] = 8'h00; req_b[3] = 8'h5A;
    req_valid = 4'b0001; push(0, 8'hFF);
    @(negedge clk); chk("t5_g0", req_ready, 4'b0001);
    step();
    req_valid = 4'b1000; push(3, 8'h00); push(3, 8'h00);
    @(negedge clk); chk("t5_g3a", req_ready, 4'b1000);
    step();
    @(negedge clk); chk("t5_g3b", req_ready, 4'b1000);
    step(); req_valid = '0;
    drain();

`ifdef AND_ARB_STATS_EN
    // Counter saturation at 7 and clear-wins
    do_reset();
    req_a[1] = 8'hFF; req_b[1] = 8'h22; req_valid = 4'b0010;
    for (int i = 0; i < 10; i++) begin push(1, 8'h22); step(); end
    req_valid = '0;
    @(negedge clk);
    chk("t6_sat", grant_cnt[1], 3'd7);
    chk("t6_other", grant_cnt[0], 3'd0);
    step();
    stats_clr = 1'b1; req_valid = 4'b0010; push(1, 8'h22);
    @(negedge clk); chk("t6_clr_grant", req_ready, 4'b0010);
    step(); stats_clr = 1'b0; req_valid = '0;
    @(negedge clk); chk("t6_clr", grant_cnt[1], 3'd0);
    drain();
`endif

    // N_REQ=2: alternating grants with ptr wrap 1 -> 0
    do_reset();
    a2[0] = 8'hFF; a2[1] = 8'hFF; b2[0] = 8'h0F; b2[1] = 8'hF0; v2 = 2'b11;
    @(negedge clk); chk("n2_g0", rdy2, 2'b01); step();
    @(negedge clk); chk("n2_g1", rdy2, 2'b10); step();
    @(negedge clk); chk("n2_wrap", rdy2, 2'b01);
    chk("n2_id0", oid2, 1'b0); chk("n2_d0", od2, 8'h0F); step();
    @(negedge clk); chk("n2_g1b", rdy2, 2'b10);
    chk("n2_id1", oid2, 1'b1); chk("n2_d1", od2, 8'hF0); step();
    v2 = '0;
    step();

    chk("sb_final", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
